// File: rtl/fadd_arb.sv
// Round-robin scheduler sharing one combinational FP32 adder among N requesters,
// with an operand register (S1) and a result register (S2) under consumer backpressure.

module fadd (
    input  logic [31:0] x0_i,
    input  logic [31:0] x1_i,
    output logic [31:0] y_o
);
    logic [7:0]  e0, e1, d;
    logic [23:0] m0, m1, m1s, mag;
    logic [22:0] norm;
    logic [24:0] sum;
    logic [4:0]  lz;
    logic [8:0]  e_res;
    logic        sgn;

    // X0 is expected to carry the larger (or equal) exponent; X1 is aligned to it.
    always_comb begin
        e0    = x0_i[30:23];
        e1    = x1_i[30:23];
        m0    = (e0 == 8'd0) ? 24'd0 : {1'b1, x0_i[22:0]};
        m1    = (e1 == 8'd0) ? 24'd0 : {1'b1, x1_i[22:0]};
        d     = e0 - e1;
        m1s   = m1 >> d;
        sum   = '0;
        mag   = '0;
        sgn   = x0_i[31];
        e_res = {1'b0, e0};
        if (x0_i[31] == x1_i[31]) begin
            sum = {1'b0, m0} + {1'b0, m1s};
            mag = sum[24] ? sum[24:1] : sum[23:0];
            if (sum[24]) begin
                e_res = e_res + 9'd1;
            end
        end else if (m1s > m0) begin
            mag = m1s - m0;
            sgn = x1_i[31];
        end else begin
            mag = m0 - m1s;
        end
        lz = '0;
        for (int i = 0; i < 24; i++) begin
            if (mag[i]) begin
                lz = 5'(23 - i);
            end
        end
        norm = 23'(mag << lz);
        // Zero magnitude or exponent underflow flushes to +0.
        if (mag == 24'd0 || e_res <= {4'd0, lz}) begin
            y_o = '0;
        end else begin
            y_o = {sgn, 8'(e_res - {4'd0, lz}), norm};
        end
    end
endmodule

module fadd_arb #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    REQ,
    input  logic [32*N-1:0] A,
    input  logic [32*N-1:0] B,
    output logic [N-1:0]    GNT,
    output logic            VLD_O,
    input  logic            RDY_I,
    output logic [W-1:0]    ID_O,
    output logic [31:0]     Y_O
);
    logic          s1_v_q;
    logic [W-1:0]  s1_id_q;
    logic [31:0]   s1_x0_q, s1_x1_q;
    logic          vld_q;
    logic [W-1:0]  id_q;
    logic [31:0]   y_q;
    logic [W-1:0]  ptr_q;

    logic          s1_en, s2_en, any_req, grant;
    logic [W-1:0]  win;
    logic [31:0]   a_w, b_w, x0_d, x1_d, fadd_y;

    assign s2_en = !vld_q | RDY_I;
    assign s1_en = !s1_v_q | s2_en;
    assign grant = any_req & s1_en;

    // Search starts just after the last granted index and wraps modulo N.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!any_req && REQ[i] && (i == (int'(ptr_q) + k) % N)) begin
                    any_req = 1'b1;
                    win     = W'(i);
                end
            end
        end
    end

    always_comb begin
        GNT = '0;
        a_w = '0;
        b_w = '0;
        for (int i = 0; i < N; i++) begin
            GNT[i] = grant && (win == W'(i));
            if (win == W'(i)) begin
                a_w = A[32*i +: 32];
                b_w = B[32*i +: 32];
            end
        end
    end

    // Larger exponent goes to X0; ties keep A in X0.
    always_comb begin
        if (b_w[30:23] > a_w[30:23]) begin
            x0_d = b_w;
            x1_d = a_w;
        end else begin
            x0_d = a_w;
            x1_d = b_w;
        end
    end

    fadd u_fadd (
        .x0_i (s1_x0_q),
        .x1_i (s1_x1_q),
        .y_o  (fadd_y)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v_q  <= 1'b0;
            s1_id_q <= '0;
            s1_x0_q <= '0;
            s1_x1_q <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            y_q     <= '0;
            ptr_q   <= W'(N - 1);
        end else begin
            if (s2_en) begin
                vld_q <= s1_v_q;
                if (s1_v_q) begin
                    id_q <= s1_id_q;
                    y_q  <= fadd_y;
                end
            end
            if (s1_en) begin
                s1_v_q <= grant;
                if (grant) begin
                    s1_id_q <= win;
                    s1_x0_q <= x0_d;
                    s1_x1_q <= x1_d;
                    ptr_q   <= win;
                end
            end
        end
    end

    assign VLD_O = vld_q;
    assign ID_O  = id_q;
    assign Y_O   = y_q;
endmodule

// File: tb/tb_fadd_arb.sv
// Bench for fadd_arb: directed test-plan scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.

module tb_fadd_arb;
    localparam int N = 4;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    REQ;
    logic [32*N-1:0] A, B;
    logic [N-1:0]    GNT;
    logic            VLD_O;
    logic            RDY_I;
    logic [1:0]      ID_O;
    logic [31:0]     Y_O;

    fadd_arb #(.N(N)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .A     (A),
        .B     (B),
        .GNT   (GNT),
        .VLD_O (VLD_O),
        .RDY_I (RDY_I),
        .ID_O  (ID_O),
        .Y_O   (Y_O)
    );

    initial forever #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference adder: exact signed integer arithmetic on aligned mantissas.
    function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x0, x1;
        longint v0, v1, r, mag;
        int e0, e1, e, d;
        if (b[30:23] > a[30:23]) begin x0 = b; x1 = a; end
        else begin x0 = a; x1 = b; end
        e0 = int'(x0[30:23]);
        e1 = int'(x1[30:23]);
        d  = e0 - e1;
        v0 = (e0 == 0) ? 0 : longint'({1'b1, x0[22:0]});
        v1 = (e1 == 0) ? 0 : longint'({1'b1, x1[22:0]});
        v1 = (d >= 62) ? 0 : (v1 >> d);
        if (x0[31]) v0 = -v0;
        if (x1[31]) v1 = -v1;
        r   = v0 + v1;
        mag = (r < 0) ? -r : r;
        e   = e0;
        while (mag >= (longint'(1) << 24)) begin mag = mag >> 1; e++; end
        while (mag != 0 && mag < (longint'(1) << 23)) begin mag = mag << 1; e--; end
        if (mag == 0 || e <= 0) return 32'd0;
        return {(r < 0) ? 1'b1 : 1'b0, 8'(e), 23'(mag)};
    endfunction

    typedef struct {
        logic [1:0]  id;
        logic [31:0] y;
        bit          at_out;
    } item_t;

    item_t       exp_q[$];
    int          m_ptr = N - 1;
    logic [31:0] m_last_y = '0;
    logic [1:0]  m_last_id = '0;

    // Model: at most two operations in flight; a new one is accepted when
    // fewer than two are held or the oldest leaves this cycle.
    always @(negedge CLK) begin
        if (chk_en) begin
            int w;
            logic [3:0] eg;
            bit ov, xf, acc;
            item_t it;
            w = -1;
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && REQ[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            ov  = (exp_q.size() > 0) && exp_q[0].at_out;
            xf  = ov && RDY_I;
            acc = (exp_q.size() < 2) || xf;
            eg  = (w >= 0 && acc) ? 4'(1 << w) : 4'd0;
            check("gnt", 32'(GNT), 32'(eg));
            check("vld", 32'(VLD_O), 32'(ov));
            check("id", 32'(ID_O), 32'(m_last_id));
            check("y", Y_O, m_last_y);
            if (RST) begin
                exp_q.delete();
                m_ptr     = N - 1;
                m_last_y  = '0;
                m_last_id = '0;
            end else begin
                if (xf) void'(exp_q.pop_front());
                if (exp_q.size() > 0 && !exp_q[0].at_out) begin
                    it = exp_q.pop_front();
                    it.at_out = 1'b1;
                    exp_q.push_front(it);
                    m_last_y  = it.y;
                    m_last_id = it.id;
                end
                if (eg != 4'd0) begin
                    it.id     = 2'(w);
                    it.y      = fadd_model(A[32*w +: 32], B[32*w +: 32]);
                    it.at_out = 1'b0;
                    exp_q.push_back(it);
                    m_ptr = w;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        A[32*i +: 32] = a;
        B[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        REQ = '0;
        RST = 1'b1;
        cyc();
        RST = 1'b0;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        e = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(100, 150));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic new_ops(input int i);
        logic [31:0] a, b;
        a = rand_fp();
        b = rand_fp();
        if ($urandom_range(0, 3) == 0) b[30:23] = a[30:23];
        set_op(i, a, b);
    endtask

    int exp_g[5];
    logic [N-1:0] gr;

    initial begin
        RST = 1'b1; REQ = '0; A = '0; B = '0; RDY_I = 1'b0;
        exp_g = '{1, 2, 4, 8, 1};

        check("model_1p2", fadd_model(32'h3F800000, 32'h40000000), 32'h40400000);
        check("model_3m1", fadd_model(32'h40400000, 32'hBF800000), 32'h40000000);
        check("model_1m1", fadd_model(32'h3F800000, 32'hBF800000), 32'h00000000);
        check("model_eqx", fadd_model(32'h3F800000, 32'hBFC00000), 32'hBF000000);

        cyc();
        chk_en = 1'b1;
        cyc();
        RST = 1'b0;
        mid();
        check("rst_vld", 32'(VLD_O), 32'd0);
        check("rst_y", Y_O, 32'd0);
        check("rst_id", 32'(ID_O), 32'd0);
        cyc();

        // Single operation with operand swap
        set_op(0, 32'h3F800000, 32'h40000000);
        REQ = 4'b0001; RDY_I = 1'b1;
        mid(); check("single_gnt", 32'(GNT), 32'h1);
        cyc(); REQ = '0;
        cyc();
        mid();
        check("single_vld", 32'(VLD_O), 32'd1);
        check("single_y", Y_O, 32'h40400000);
        check("single_id", 32'(ID_O), 32'd0);
        cyc();

        // Round-robin wrap
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 32'h40000000, 32'h3F800000 + 32'(i));
        REQ = 4'b1111;
        for (int j = 0; j < 7; j++) begin
            mid();
            if (j < 5) check("rr_gnt", 32'(GNT), 32'(exp_g[j]));
            if (j >= 2) begin
                check("rr_vld", 32'(VLD_O), 32'd1);
                check("rr_id", 32'(ID_O), 32'((j - 2) % 4));
            end
            cyc();
        end
        REQ = '0;

        // Skip and priority
        do_reset();
        REQ = 4'b0100; mid(); check("skip_g2", 32'(GNT), 32'h4); cyc();
        REQ = 4'b0101; mid(); check("skip_g0", 32'(GNT), 32'h1); cyc();
        REQ = 4'b0100; mid(); check("skip_g2b", 32'(GNT), 32'h4); cyc();
        REQ = '0;

        // Backpressure from reset
        do_reset();
        RDY_I = 1'b0;
        set_op(0, 32'h3F800000, 32'h40000000);
        for (int i = 1; i < N; i++) set_op(i, 32'h40000000, 32'h40000000);
        REQ = 4'b1111;
        mid(); check("bp_g0", 32'(GNT), 32'h1); cyc();
        mid(); check("bp_g1", 32'(GNT), 32'h2); cyc();
        for (int j = 0; j < 4; j++) begin
            mid();
            check("bp_gnt0", 32'(GNT), 32'd0);
            check("bp_hold_vld", 32'(VLD_O), 32'd1);
            check("bp_hold_id", 32'(ID_O), 32'd0);
            check("bp_hold_y", Y_O, 32'h40400000);
            cyc();
        end
        RDY_I = 1'b1;
        for (int j = 0; j < 6; j++) begin
            mid();
            check("bp_drain_vld", 32'(VLD_O), 32'd1);
            check("bp_drain_id", 32'(ID_O), 32'(j % 4));
            cyc();
        end

        // Reset while the pipeline is full
        RST = 1'b1;
        cyc();
        RST = 1'b0; REQ = '0;
        for (int j = 0; j < 3; j++) begin
            mid();
            check("mrst_vld", 32'(VLD_O), 32'd0);
            check("mrst_y", Y_O, 32'd0);
            check("mrst_id", 32'(ID_O), 32'd0);
            cyc();
        end
        set_op(3, 32'h40400000, 32'hBF800000);
        REQ = 4'b1000;
        mid(); check("mrst_g3", 32'(GNT), 32'h8);
        cyc(); REQ = '0;
        cyc();
        mid();
        check("mrst_vld3", 32'(VLD_O), 32'd1);
        check("mrst_id3", 32'(ID_O), 32'd3);
        check("mrst_y3", Y_O, 32'h40000000);
        cyc();

        // Subtraction and exact cancellation
        do_reset();
        set_op(0, 32'h40400000, 32'hBF800000);
        REQ = 4'b0001;
        mid(); check("sub_g0", 32'(GNT), 32'h1); cyc();
        set_op(0, 32'h3F800000, 32'hBF800000);
        mid(); check("sub_g0b", 32'(GNT), 32'h1); cyc();
        REQ = '0;
        mid(); check("sub_y", Y_O, 32'h40000000); check("sub_v", 32'(VLD_O), 32'd1); cyc();
        mid(); check("zero_y", Y_O, 32'h00000000); check("zero_v", 32'(VLD_O), 32'd1); cyc();

        // Randomized traffic with withdrawals, backpressure and occasional reset
        for (int i = 0; i < N; i++) new_ops(i);
        for (int c = 0; c < 3000; c++) begin
            mid();
            gr = GNT & REQ;
            cyc();
            for (int i = 0; i < N; i++) begin
                if (gr[i]) begin
                    REQ[i] = 1'($urandom_range(0, 1));
                    new_ops(i);
                end else if (REQ[i]) begin
                    if ($urandom_range(0, 19) == 0) REQ[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    REQ[i] = 1'b1;
                    new_ops(i);
                end
            end
            RDY_I = ($urandom_range(0, 9) < 7);
            RST   = ($urandom_range(0, 399) == 0);
        end

        RST = 1'b0; REQ = '0; RDY_I = 1'b1;
        repeat (6) cyc();
        mid();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
